// File: rtl/blur_stream_img.sv
// Purpose : 3x3 Gaussian blur (edge clamp, rounded) or 2x decimation of a
//           run-time sized image, BRAM source to BRAM destination.
// Latency : blur N+READ_LATENCY+1 cycles per pixel (N=9 at x=0, else 3);
//           decimate writes pixel k READ_LATENCY cycles after its read.
// Backpressure: none. The BRAMs are assumed always ready. start_in is only
//           honoured in IDLE and is dropped while a frame is running.
// Ports   : clk_in/rst_in (async, active-high); width_in/height_in/mode_in
//           are latched with start_in. ext_read_addr(_valid) and ext_pixel_in
//           form the source read port. ext_write_addr/ext_write_valid/
//           ext_pixel_out form the destination write port. busy_out,
//           done_out and error_out report status.
module blur_stream_img #(
  parameter int BIT_DEPTH    = 8,
  parameter int MAX_WIDTH    = 64,
  parameter int MAX_HEIGHT   = 64,
  parameter int READ_LATENCY = 2,
  localparam int AW = $clog2(MAX_WIDTH * MAX_HEIGHT),
  localparam int WW = $clog2(MAX_WIDTH + 1),
  localparam int HW = $clog2(MAX_HEIGHT + 1)
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [WW-1:0]        width_in,
  input  logic [HW-1:0]        height_in,
  input  logic                 mode_in,
  input  logic                 start_in,
  output logic [AW-1:0]        ext_read_addr,
  output logic                 ext_read_addr_valid,
  input  logic [BIT_DEPTH-1:0] ext_pixel_in,
  output logic [AW-1:0]        ext_write_addr,
  output logic                 ext_write_valid,
  output logic [BIT_DEPTH-1:0] ext_pixel_out,
  output logic                 busy_out,
  output logic                 done_out,
  output logic                 error_out
);

  localparam int PW  = WW + HW;
  localparam int SW  = BIT_DEPTH + 4;
  localparam int DCW = $clog2(READ_LATENCY + 2);

  typedef enum logic [2:0] {
    IDLE,
    BLUR_FETCH,
    BLUR_DRAIN,
    BLUR_WRITE,
    DEC_RUN,
    DEC_DRAIN,
    DONE
  } state_t;

  state_t state_q, state_d;

  // Frame parameters, latched on an accepted start.
  logic [WW-1:0]        w_q;
  logic [HW-1:0]        h_q;
  logic                 mode_q;

  // Current pixel (blur) or current output pixel (decimate).
  logic [WW-1:0]        x_q, x_d;
  logic [HW-1:0]        y_q, y_d;

  // Window column/row of the read being issued.
  logic [1:0]           col_q, row_q;
  logic [DCW-1:0]       drn_q;
  logic                 last_q;
  logic                 err_q;
  logic [AW-1:0]        wr_addr_q;
  logic [BIT_DEPTH-1:0] pix_q;

  // win_q[col][row]: col 0/1/2 = x-1/x/x+1, row 0/1/2 = y-1/y/y+1.
  logic [BIT_DEPTH-1:0] win_q [3][3];

  // Read tag pipeline {valid, col, row}, aligned so the last stage matches
  // the cycle in which ext_pixel_in carries that read's data.
  logic [4:0]           tag_q [READ_LATENCY];

  logic                 start_ok;
  logic                 x_end, y_end, dec_x_end, dec_y_end;
  logic                 compute;
  logic                 rd_vld, wr_vld;
  logic                 ret_vld;
  logic [1:0]           ret_col, ret_row;
  logic [WW-1:0]        ow, bx, dx;
  logic [HW-1:0]        oh, by, dy;
  logic [AW-1:0]        rd_addr;
  logic [SW-1:0]        sum;
  logic [BIT_DEPTH-1:0] blur_pix;

  function automatic logic [AW-1:0] pix_addr(input logic [WW-1:0] px,
                                             input logic [HW-1:0] py,
                                             input logic [WW-1:0] pw);
    logic [PW-1:0] full;
    full = PW'(py) * PW'(pw) + PW'(px);
    return AW'(full);
  endfunction

  // ---------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------
  assign start_ok = (width_in != '0) && (height_in != '0) &&
                    (width_in <= WW'(MAX_WIDTH)) && (height_in <= HW'(MAX_HEIGHT)) &&
                    !(mode_in && ((width_in < WW'(2)) || (height_in < HW'(2))));

  assign x_end     = (x_q == w_q - WW'(1));
  assign y_end     = (y_q == h_q - HW'(1));
  assign ow        = w_q >> 1;
  assign oh        = h_q >> 1;
  assign dec_x_end = (x_q == ow - WW'(1));
  assign dec_y_end = (y_q == oh - HW'(1));
  assign dx        = {x_q[WW-2:0], 1'b0};
  assign dy        = {y_q[HW-2:0], 1'b0};

  // The last drain cycle: every tap of the window has landed.
  assign compute = (state_q == BLUR_DRAIN) && (drn_q == DCW'(READ_LATENCY));

  assign {ret_vld, ret_col, ret_row} = tag_q[READ_LATENCY-1];

  // Clamped source coordinates for the tap being read.
  always_comb begin
    bx = x_q;
    if (col_q == 2'd0 && x_q != '0) begin
      bx = x_q - WW'(1);
    end else if (col_q == 2'd2 && !x_end) begin
      bx = x_q + WW'(1);
    end
    by = y_q;
    if (row_q == 2'd0 && y_q != '0) begin
      by = y_q - HW'(1);
    end else if (row_q == 2'd2 && !y_end) begin
      by = y_q + HW'(1);
    end
  end

  // The write cycle of one pixel also issues the first read of the next.
  assign rd_vld  = (state_q == BLUR_FETCH) ||
                   (state_q == BLUR_WRITE && !last_q) ||
                   (state_q == DEC_RUN);
  assign rd_addr = mode_q ? pix_addr(dx, dy, w_q) : pix_addr(bx, by, w_q);

  // Decimation writes straight through from the returning read data.
  assign wr_vld  = (state_q == BLUR_WRITE) || (mode_q && ret_vld);

  // Weights [1 2 1; 2 4 2; 1 2 1]; maximum 16*(2^BIT_DEPTH-1) fits in SW.
  always_comb begin
    sum = SW'(win_q[0][0]) + SW'(win_q[0][2]) + SW'(win_q[2][0]) + SW'(win_q[2][2])
        + (SW'(win_q[0][1]) << 1) + (SW'(win_q[1][0]) << 1)
        + (SW'(win_q[1][2]) << 1) + (SW'(win_q[2][1]) << 1)
        + (SW'(win_q[1][1]) << 2);
    blur_pix = BIT_DEPTH'((sum + SW'(8)) >> 4);
  end

  assign ext_read_addr_valid = rd_vld;
  assign ext_read_addr       = rd_vld ? rd_addr : '0;
  assign ext_write_valid     = wr_vld;
  assign ext_write_addr      = wr_vld ? wr_addr_q : '0;
  assign ext_pixel_out       = wr_vld ? (mode_q ? ext_pixel_in : pix_q) : '0;
  assign error_out           = err_q;

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    busy_out = 1'b0;
    done_out = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_in && start_ok) begin
          state_d = mode_in ? DEC_RUN : BLUR_FETCH;
        end
      end
      BLUR_FETCH: begin
        busy_out = 1'b1;
        if (col_q == 2'd2 && row_q == 2'd2) begin
          state_d = BLUR_DRAIN;
        end
      end
      BLUR_DRAIN: begin
        busy_out = 1'b1;
        if (compute) begin
          state_d = BLUR_WRITE;
        end
      end
      BLUR_WRITE: begin
        busy_out = 1'b1;
        state_d  = last_q ? DONE : BLUR_FETCH;
      end
      DEC_RUN: begin
        busy_out = 1'b1;
        if (dec_x_end && dec_y_end) begin
          state_d = DEC_DRAIN;
        end
      end
      DEC_DRAIN: begin
        busy_out = 1'b1;
        if (drn_q == DCW'(READ_LATENCY - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_out = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Next pixel position: blur advances after computing, decimate per read.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (compute) begin
      if (x_end) begin
        x_d = '0;
        y_d = y_q + HW'(1);
      end else begin
        x_d = x_q + WW'(1);
      end
    end else if (state_q == DEC_RUN) begin
      if (dec_x_end) begin
        x_d = '0;
        y_d = y_q + HW'(1);
      end else begin
        x_d = x_q + WW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      w_q       <= '0;
      h_q       <= '0;
      mode_q    <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      col_q     <= '0;
      row_q     <= '0;
      drn_q     <= '0;
      last_q    <= 1'b0;
      err_q     <= 1'b0;
      wr_addr_q <= '0;
      pix_q     <= '0;
      for (int c = 0; c < 3; c++) begin
        for (int r = 0; r < 3; r++) begin
          win_q[c][r] <= '0;
        end
      end
      for (int k = 0; k < READ_LATENCY; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      err_q    <= 1'b0;
      x_q      <= x_d;
      y_q      <= y_d;
      tag_q[0] <= {rd_vld, col_q, row_q};
      for (int k = 1; k < READ_LATENCY; k++) begin
        tag_q[k] <= tag_q[k-1];
      end

      if (state_q == BLUR_DRAIN || state_q == DEC_DRAIN) begin
        drn_q <= drn_q + DCW'(1);
      end else begin
        drn_q <= '0;
      end

      if (state_q == IDLE && start_in) begin
        if (start_ok) begin
          w_q       <= width_in;
          h_q       <= height_in;
          mode_q    <= mode_in;
          x_q       <= '0;
          y_q       <= '0;
          col_q     <= '0;
          row_q     <= '0;
          wr_addr_q <= '0;
          last_q    <= 1'b0;
        end else begin
          err_q <= 1'b1;
        end
      end

      // Walk the window: rows fastest, then columns.
      if (rd_vld && !mode_q) begin
        if (row_q == 2'd2) begin
          row_q <= '0;
          col_q <= col_q + 2'd1;
        end else begin
          row_q <= row_q + 2'd1;
        end
      end

      if (ret_vld && !mode_q) begin
        win_q[ret_col][ret_row] <= ext_pixel_in;
      end

      if (ret_vld && mode_q) begin
        wr_addr_q <= wr_addr_q + AW'(1);
      end

      if (compute) begin
        pix_q     <= blur_pix;
        wr_addr_q <= pix_addr(x_q, y_q, w_q);
        last_q    <= x_end && y_end;
        row_q     <= '0;
        if (x_end) begin
          col_q <= 2'd0;   // new row: reload all nine taps
        end else begin
          col_q <= 2'd2;   // slide: only the right column is fetched
          for (int r = 0; r < 3; r++) begin
            win_q[0][r] <= win_q[1][r];
            win_q[1][r] <= win_q[2][r];
          end
        end
      end
    end
  end

endmodule
